ex_mem_stage_reg: RTL

- Parametrised EX->MEM pipeline register; successor to the fixed-width, always-load EX/MEM flop bank.
- Carries the ALU result, store data, destination register and memory/writeback control through a valid/ready handshake.
- A 2-entry skid buffer lets the downstream MEM stage stall without a combinational ready path back into EX.
- Adds a synchronous flush (bubble insertion) and a saturating stall-cycle counter.

---
 rtl/ex_mem_if.sv | 30 +++
 rtl/ex_mem_stage_reg.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ex_mem_if.sv
// EX->MEM valid/ready bundle: handshake plus ALU result, store data,
// destination register and memory/writeback control.
interface ex_mem_if #(
   parameter int DATA_W = 64,
   parameter int RD_W   = 5,
   parameter int MTR_W  = 2
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] write_data;
   logic [RD_W-1:0]   rd;
   logic [MTR_W-1:0]  mem_to_reg;
   logic              reg_write;
   logic              mem_write;
   logic              read_enable;
   logic              choose_rd;

   modport master (
      output valid, alu_result, write_data, rd, mem_to_reg,
      output reg_write, mem_write, read_enable, choose_rd,
      input  ready
   );

   modport slave (
      input  valid, alu_result, write_data, rd, mem_to_reg,
      input  reg_write, mem_write, read_enable, choose_rd,
      output ready
   );
endinterface

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register with 2-entry skid buffer, synchronous flush
// and a saturating stall-cycle counter.
module ex_mem_stage_reg #(
   parameter int DATA_W = 64,
   parameter int RD_W   = 5,
   parameter int MTR_W  = 2,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   ex_mem_if.slave          ex,
   ex_mem_if.master         mem,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef struct packed {
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] write_data;
      logic [RD_W-1:0]   rd;
      logic [MTR_W-1:0]  mem_to_reg;
      logic              reg_write;
      logic              mem_write;
      logic              read_enable;
      logic              choose_rd;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   entry_t main_q;
   entry_t skid_q;
   entry_t in_e;
   logic   main_valid;
   logic   skid_valid;
   logic   accept;
   logic   consume;
   logic   ld_main_in;
   logic   ld_main_skid;
   logic   ld_skid;

   assign in_e = '{
      alu_result:  ex.alu_result,
      write_data:  ex.write_data,
      rd:          ex.rd,
      mem_to_reg:  ex.mem_to_reg,
      reg_write:   ex.reg_write,
      mem_write:   ex.mem_write,
      read_enable: ex.read_enable,
      choose_rd:   ex.choose_rd
   };

   assign main_valid = (state != EMPTY);
   assign skid_valid = (state == FULL);
   // ready depends only on registered state, never on mem.ready
   assign ex.ready   = !skid_valid;
   assign accept     = ex.valid & ex.ready;
   assign consume    = main_valid & mem.ready;

   always_comb begin
      state_nxt    = state;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  state_nxt  = ONE;
                  ld_main_in = 1'b1;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  ld_main_in = 1'b1;
               end else if (accept) begin
                  state_nxt = FULL;
                  ld_skid   = 1'b1;
               end else if (consume) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (consume) begin
                  state_nxt    = ONE;
                  ld_main_skid = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         main_q.reg_write   <= 1'b0;
         main_q.mem_write   <= 1'b0;
         main_q.read_enable <= 1'b0;
         skid_q.reg_write   <= 1'b0;
         skid_q.mem_write   <= 1'b0;
         skid_q.read_enable <= 1'b0;
      end else begin
         if (ld_main_in) begin
            main_q <= in_e;
         end else if (ld_main_skid) begin
            main_q <= skid_q;
         end
         if (ld_skid) begin
            skid_q <= in_e;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (main_valid && !mem.ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign mem.valid       = main_valid;
   assign mem.alu_result  = main_q.alu_result;
   assign mem.write_data  = main_q.write_data;
   assign mem.rd          = main_q.rd;
   assign mem.mem_to_reg  = main_q.mem_to_reg;
   assign mem.reg_write   = main_q.reg_write & main_valid;
   assign mem.mem_write   = main_q.mem_write & main_valid;
   assign mem.read_enable = main_q.read_enable & main_valid;
   assign mem.choose_rd   = main_q.choose_rd & main_valid;
endmodule
